store_rmw: RTL and testbench
============================

# store_rmw

Store-side narrowing unit for the data-memory path: the write-direction counterpart of immediate and load extension. Takes a 32-bit register value plus a store op (sw/sh/sb), truncates it to the selected width, and places it in the correct byte lane of a word-wide data memory. Sub-word stores use a read-modify-write sequence. The block sits between the MEM-stage controller and a word-addressed synchronous RAM that has no byte enables.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_data`  in  32  register value; only the low byte or half is used for sb/sh.
- `SOp`  in  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- `mem_addr`  out  ADDR_WIDTH  word address, `{req_addr[ADDR_WIDTH-1:2], 2'b00}`, held for the whole operation.
- `mem_re`  out  1  read strobe; RAM returns `mem_rdata` on the following cycle.
- `mem_rdata`  in  32  RAM read data.
- `mem_we`  out  1  write strobe, one cycle.
- `mem_wdata`  out  32  merged word.
- `mem_be`  out  4  byte lanes modified (debug/trace only).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  coincident with `done` for a rejected request.

## Operation
- **Capture.** On accept, register addr, data and SOp.
- **FSM states:** IDLE, READ, CAPT, WRITE, ERR.
- **IDLE transitions on accept:**
  - sw with `addr[1:0]==0` → WRITE.
  - sh with `addr[0]==0` → READ.
  - sb → READ.
  - Any other case → ERR: misaligned sw, misaligned sh, or SOp = 11.
- **READ:** `mem_re=1` → CAPT.
- **CAPT:** latch `mem_rdata` into the merge register → WRITE.
- **WRITE:** `mem_we=1`, `done=1` → IDLE.
- **ERR:** `done=1`, `err=1`; no memory strobes → IDLE.
- **Merge** (lane = `addr[1:0]`):
  - sw: `wdata = data`, `be = 1111`.
  - sh, `addr[1]==0`: `{old[31:16], data[15:0]}`, `be = 0011`.
  - sh, `addr[1]==1`: `{data[15:0], old[15:0]}`, `be = 1100`.
  - sb: `data[7:0]` replaces `old[8*lane+7 : 8*lane]`; `be = 0001 << lane`.
- **Truncation:** bits of `req_data` above the stored width are ignored. There is no sign or zero handling on the write side.
- **Output gating:** `mem_wdata` and `mem_be` are valid only while `mem_we=1`; they are 0 otherwise.

## Timing
- **Reset values:** state = IDLE, `req_ready=1`, `mem_re=0`, `mem_we=0`, `done=0`, `err=0`, `mem_wdata=0`, `mem_be=0`, `mem_addr=0`.
- **Requests during reset:** a request presented in a cycle with `reset=1` is ignored.
- **Latency from the accept edge (cycle 0):**
  - sw: write and `done` in cycle 1.
  - sh/sb: `mem_re` in cycle 1, capture in cycle 2, write and `done` in cycle 3.
  - error: `done`/`err` in cycle 1.
- **Back-to-back:** `req_ready` returns high in the cycle after `done`. There is no overlap between operations. Minimum issue interval is 2 cycles for sw and 4 for sh/sb.
- **Busy:** `req_valid` while busy is not accepted. The requester must hold the request until it sees `req_ready`.
- **Reset mid-operation:** the FSM returns to IDLE next edge. A pending write is dropped (no `mem_we`), and no `done` is produced.
- **Address:** `mem_addr` is constant from cycle 1 until `done`.

## Structure
- **Shared package** (`mem_defs`):
  - SOp encodings: `SOP_SW`, `SOP_SH`, `SOP_SB`.
  - FSM state encoding.
  - The alignment-check function, reused by the load-extension unit.
- **Sub-module `store_merge`** (combinational): inputs `old`, `data`, `SOp`, `lane`; outputs `wdata`, `be`. It is unit-testable standalone.
- **Top module:** FSM, capture registers, strobe generation.

## Test plan
- **sw aligned:** sw addr 0x0000_0010, data 0xDEAD_BEEF → cycle 1: `mem_we=1`, `mem_addr=0x10`, `wdata=0xDEADBEEF`, `be=1111`, `done=1`, no `mem_re`.
- **sb, all four lanes:** RAM word 0x1122_3344, sb data 0xFFFF_FFAB at addr offsets 0..3 → `wdata` 0x112233AB, 0x1122AB44, 0x11AB3344, 0xAB223344; `done` at cycle 3.
- **sh, both halves:** RAM word 0x1122_3344, sh data 0x0000_CAFE at offset 2 → `wdata 0xCAFE3344`, `be=1100`; at offset 0 → `wdata 0x1122CAFE`.
- **Errors:**
  - sh at offset 1 → `done=err=1` at cycle 1, no strobes.
  - sw at offset 2 → same response.
  - SOp = 11 → same response.
- **Reset mid-op:** sb accepted, `reset=1` in cycle 2 → no `mem_we`, no `done`, `req_ready=1` the cycle after reset deasserts.
- **Back-to-back:** `req_valid` held continuously with sw, sb, sw → accepts at cycles 0, 2, 6; `req_ready=0` while busy; the held request is not lost.

Source files
------------

// File: rtl/mem_defs.sv
// Shared data-memory definitions: store op encodings, store FSM
// states and the alignment check shared with the load-extension unit.
package mem_defs;

  localparam logic [1:0] SOP_SW = 2'b00;
  localparam logic [1:0] SOP_SH = 2'b01;
  localparam logic [1:0] SOP_SB = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Reserved encodings are never aligned, so they fall into the error path.
  function automatic logic is_aligned(
    input logic [1:0] sop,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (sop)
      SOP_SW:  ok = (off == 2'b00);
      SOP_SH:  ok = !off[0];
      SOP_SB:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: places a truncated store value into
// the old memory word and reports which byte lanes changed.
module store_merge
  import mem_defs::*;
(
  input  logic [31:0] old,
  input  logic [31:0] data,
  input  logic [1:0]  SOp,
  input  logic [1:0]  lane,
  output logic [31:0] wdata,
  output logic [3:0]  be
);

  always_comb begin
    wdata = old;
    be    = 4'b0000;
    unique case (SOp)
      SOP_SW: begin
        wdata = data;
        be    = 4'b1111;
      end
      SOP_SH: begin
        if (lane[1]) begin
          wdata = {data[15:0], old[15:0]};
          be    = 4'b1100;
        end else begin
          wdata = {old[31:16], data[15:0]};
          be    = 4'b0011;
        end
      end
      SOP_SB: begin
        be = 4'b0001 << lane;
        for (int i = 0; i < 4; i++) begin
          if (lane == i[1:0]) wdata[8*i +: 8] = data[7:0];
        end
      end
      default: begin
        wdata = old;
        be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/store_rmw.sv
// Store narrowing unit: sw writes directly, sh/sb do read-modify-write
// against a word RAM without byte enables.
module store_rmw
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            SOp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  done,
  output logic                  err
);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [1:0]            r_sop;
  logic [31:0]           r_old;

  logic [2:0]  w_next;
  logic        w_accept;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!is_aligned(SOp, req_addr[1:0])) w_next = ST_ERR;
          else if (SOp == SOP_SW)             w_next = ST_WRITE;
          else                                w_next = ST_READ;
        end
      end
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      ST_ERR:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_sop   <= SOP_SW;
      r_old   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_data;
        r_sop  <= SOp;
      end
      if (r_state == ST_CAPT) r_old <= mem_rdata;
    end
  end

  store_merge u_merge (
    .old   (r_old),
    .data  (r_data),
    .SOp   (r_sop),
    .lane  (r_addr[1:0]),
    .wdata (w_wdata),
    .be    (w_be)
  );

  // Strobes are masked by reset so an in-flight write is dropped.
  assign w_we      = (r_state == ST_WRITE) && !reset;
  assign req_ready = (r_state == ST_IDLE);
  assign mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_re    = (r_state == ST_READ) && !reset;
  assign mem_we    = w_we;
  assign mem_wdata = w_we ? w_wdata : 32'h0;
  assign mem_be    = w_we ? w_be : 4'h0;
  assign done      = (w_we || (r_state == ST_ERR)) && !reset;
  assign err       = (r_state == ST_ERR) && !reset;

endmodule

// File: tb/tb_store_rmw.sv
// Scoreboard bench for store_rmw: a word RAM model answers reads and
// every done pulse is matched against the expectation queued at accept.
module tb_store_rmw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  SOp = 2'b00;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    int          acc;
    int          lat;
    int          re_n;
  } exp_t;

  exp_t q[$];

  logic [31:0] ram [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_data;
    else if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[5:2]];
  end

  store_rmw #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .SOp       (SOp),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  task automatic monitor();
    exp_t e;
    int   re_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        re_cnt = 0;
        continue;
      end
      if (mem_re) re_cnt++;
      if (!mem_we) begin
        checks++;
        if (mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
          errors++;
          $display("FAIL gating: wdata=%h be=%b required 0", mem_wdata, mem_be);
        end
      end else if (!done) begin
        checks++;
        errors++;
        $display("FAIL we_without_done at cycle %0d", cyc);
      end
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d err=%b", cyc, err);
        end else begin
          e = q.pop_front();
          if (err !== e.err) begin
            errors++;
            $display("FAIL err: got %b required %b", err, e.err);
          end
          checks++;
          if (mem_we !== !e.err) begin
            errors++;
            $display("FAIL mem_we: got %b required %b", mem_we, !e.err);
          end
          checks++;
          if (cyc - e.acc !== e.lat) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", cyc - e.acc, e.lat);
          end
          checks++;
          if (re_cnt !== e.re_n) begin
            errors++;
            $display("FAIL re_count: got %0d required %0d", re_cnt, e.re_n);
          end
          if (!e.err) begin
            checks++;
            if (mem_addr !== e.addr) begin
              errors++;
              $display("FAIL mem_addr: got %h required %h", mem_addr, e.addr);
            end
            checks++;
            if (mem_wdata !== e.wdata) begin
              errors++;
              $display("FAIL wdata: got %h required %h", mem_wdata, e.wdata);
            end
            checks++;
            if (mem_be !== e.be) begin
              errors++;
              $display("FAIL be: got %b required %b", mem_be, e.be);
            end
          end
        end
        re_cnt = 0;
      end
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] w);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = w;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [1:0]  op,
    input  logic [31:0] xw,
    input  logic [3:0]  xb,
    input  logic        xe,
    input  logic        push,
    output int          acc
  );
    int   n = 0;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    SOp       = op;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: ready=%b required 1", req_ready);
    end
    acc = cyc;
    if (push) begin
      e.addr  = {a[31:2], 2'b00};
      e.wdata = xw;
      e.be    = xb;
      e.err   = xe;
      e.acc   = acc;
      e.lat   = (xe || op == 2'b00) ? 1 : 3;
      e.re_n  = (xe || op == 2'b00) ? 0 : 1;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pending required 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0014;
    req_data  = 32'h1234_5678;
    SOp       = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rdy=%b re=%b we=%b required 1 0 0",
               req_ready, mem_re, mem_we);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: done=%b err=%b required 0 0", done, err);
    end
    checks++;
    if (mem_wdata !== 32'h0 || mem_be !== 4'h0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: wdata=%h be=%b addr=%h required 0",
               mem_wdata, mem_be, mem_addr);
    end
    req_valid = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ignored: addr=%h rdy=%b required 0 1",
               mem_addr, req_ready);
    end
  endtask

  task automatic test_sw();
    int a;
    issue(32'h10, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, a);
    drain();
  endtask

  task automatic test_sb();
    int a;
    logic [31:0] xw [4];
    xw[0] = 32'h1122_33AB;
    xw[1] = 32'h1122_AB44;
    xw[2] = 32'h11AB_3344;
    xw[3] = 32'hAB22_3344;
    for (int l = 0; l < 4; l++) begin
      preload(4'd12, 32'h1122_3344);
      issue(32'h30 + l, 32'hFFFF_FFAB, 2'b10, xw[l], 4'b0001 << l,
            1'b0, 1'b1, a);
      drain();
    end
  endtask

  task automatic test_sh();
    int a;
    preload(4'd12, 32'h1122_3344);
    issue(32'h32, 32'h0000_CAFE, 2'b01, 32'hCAFE_3344, 4'b1100, 1'b0, 1'b1, a);
    drain();
    preload(4'd12, 32'h1122_3344);
    issue(32'h30, 32'h0000_CAFE, 2'b01, 32'h1122_CAFE, 4'b0011, 1'b0, 1'b1, a);
    drain();
  endtask

  task automatic test_errors();
    int a;
    issue(32'h31, 32'h0000_CAFE, 2'b01, 32'h0, 4'h0, 1'b1, 1'b1, a);
    drain();
    issue(32'h12, 32'hDEAD_BEEF, 2'b00, 32'h0, 4'h0, 1'b1, 1'b1, a);
    drain();
    issue(32'h10, 32'hDEAD_BEEF, 2'b11, 32'h0, 4'h0, 1'b1, 1'b1, a);
    drain();
  endtask

  task automatic test_reset_midop();
    int a;
    preload(4'd12, 32'h1122_3344);
    issue(32'h31, 32'h0000_0077, 2'b10, 32'h0, 4'h0, 1'b0, 1'b0, a);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: rdy=%b we=%b done=%b required 1 0 0",
               req_ready, mem_we, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ram[12] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL midop_ram: got %h required 11223344", ram[12]);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    issue(32'h20, 32'h5566_7788, 2'b00, 32'h5566_7788, 4'b1111, 1'b0, 1'b1, a0);
    issue(32'h21, 32'hFFFF_FFCD, 2'b10, 32'h5566_CD88, 4'b0010, 1'b0, 1'b1, a1);
    issue(32'h24, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b1, a2);
    drain();
    checks++;
    if (a1 - a0 !== 2) begin
      errors++;
      $display("FAIL b2b_gap_sw: got %0d required 2", a1 - a0);
    end
    checks++;
    if (a2 - a1 !== 4) begin
      errors++;
      $display("FAIL b2b_gap_sb: got %0d required 4", a2 - a1);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
